// File: rtl/caches_pkg.sv
// Shared types for the cache-side memory arbiter: word type, arbiter states
// and the width rule for the dcache streak counter.
package caches_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_I  = 3'd1,
        GNT_DR = 3'd2,
        GNT_DW = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

    // Counter must be able to hold DSTREAK_MAX itself; never narrower than one bit.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache-first priority with a
// streak limit for the icache, latched requests, stale detection and wait/done handshakes.
module memory_arbiter
    import caches_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        load_done,
    output logic        store_done,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [2:0]  dbg_state
);

    localparam int              SW         = streak_width(DSTREAK_MAX);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(DSTREAK_MAX);

    arb_state_t    state_q;
    arb_state_t    grant_d;
    logic [SW-1:0] streak_q;
    logic          stale_q;
    logic          mismatch;
    logic          stale_d;

    word_t iload_q, dload_q, ramaddr_q, ramstore_q;
    logic  iwait_q, dwait_q, load_done_q, store_done_q, ramren_q, ramwen_q;

    // Winner of an IDLE cycle; the streak limit overrides dcache priority.
    always_comb begin
        grant_d = IDLE;
        if (iREN && (streak_q == STREAK_MAX)) grant_d = GNT_I;
        else if (dWEN)                        grant_d = GNT_DW;
        else if (dREN)                        grant_d = GNT_DR;
        else if (iREN)                        grant_d = GNT_I;
    end

    // ramaddr_q doubles as the latched request address while granted.
    always_comb begin
        mismatch = 1'b0;
        case (state_q)
            GNT_I:   mismatch = !iREN || (iaddr != ramaddr_q);
            GNT_DR:  mismatch = !dREN || (daddr != ramaddr_q);
            GNT_DW:  mismatch = !dWEN || (daddr != ramaddr_q);
            default: mismatch = 1'b0;
        endcase
        stale_d = stale_q | mismatch;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= grant_d;
                    if (!iREN || (grant_d == GNT_I))
                        streak_q <= '0;
                    else if (((grant_d == GNT_DW) || (grant_d == GNT_DR)) && (streak_q != STREAK_MAX))
                        streak_q <= streak_q + SW'(1);
                end
                GNT_I, GNT_DR, GNT_DW: begin
                    stale_q <= stale_d;
                    if (ramready) state_q <= RESP;
                end
                RESP: begin
                    stale_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iload_q      <= '0;
            dload_q      <= '0;
            ramaddr_q    <= '0;
            ramstore_q   <= '0;
            iwait_q      <= 1'b1;
            dwait_q      <= 1'b1;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            ramren_q     <= 1'b0;
            ramwen_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (grant_d)
                        GNT_I: begin
                            ramren_q  <= 1'b1;
                            ramaddr_q <= iaddr;
                        end
                        GNT_DR: begin
                            ramren_q  <= 1'b1;
                            ramaddr_q <= daddr;
                        end
                        GNT_DW: begin
                            ramwen_q   <= 1'b1;
                            ramaddr_q  <= daddr;
                            ramstore_q <= dstore;
                        end
                        default: ;
                    endcase
                end
                GNT_I, GNT_DR, GNT_DW: begin
                    if (ramready) begin
                        ramren_q <= 1'b0;
                        ramwen_q <= 1'b0;
                        if (state_q == GNT_I)  iload_q <= ramload;
                        if (state_q == GNT_DR) dload_q <= ramload;
                        // A stale request still completes on the RAM but is not acknowledged.
                        if (!stale_d) begin
                            case (state_q)
                                GNT_I:   iwait_q <= 1'b0;
                                GNT_DR: begin
                                    dwait_q     <= 1'b0;
                                    load_done_q <= 1'b1;
                                end
                                default: begin
                                    dwait_q      <= 1'b0;
                                    store_done_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    iwait_q      <= 1'b1;
                    dwait_q      <= 1'b1;
                    load_done_q  <= 1'b0;
                    store_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign iload      = iload_q;
    assign dload      = dload_q;
    assign iwait      = iwait_q;
    assign dwait      = dwait_q;
    assign load_done  = load_done_q;
    assign store_done = store_done_q;
    assign ramREN     = ramren_q;
    assign ramWEN     = ramwen_q;
    assign ramaddr    = ramaddr_q;
    assign ramstore   = ramstore_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a transaction-level
// arbitration/memory model, with a behavioural RAM answering the DUT's port.
module tb_memory_arbiter;
    import caches_pkg::*;

    localparam int DMAX = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, load_done, store_done, ramREN, ramWEN;
    logic [31:0] ramload = '0;
    logic        ramready = 1'b0;
    logic [2:0]  dbg_state;

    memory_arbiter #(.DSTREAK_MAX(DMAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait), .load_done(load_done), .store_done(store_done),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    word_t ram_mem[word_t];
    word_t ref_mem[word_t];
    logic [33:0] exp_q[$];

    function automatic word_t init_word(input word_t a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Behavioural RAM: completes an access ram_lat cycles after enable (0 = random 1..3).
    int ram_lat = 1;
    int ram_cnt = 0;
    int ram_tgt = 1;
    always begin
        @(posedge CLK);
        #2;
        if (RST) begin
            ramready = 1'b0;
            ram_cnt  = 0;
        end else if (ramready) begin
            ramready = 1'b0;
        end else if (ramREN || ramWEN) begin
            if (ram_cnt == 0) ram_tgt = (ram_lat == 0) ? int'($urandom_range(1, 3)) : ram_lat;
            ram_cnt++;
            if (ram_cnt >= ram_tgt) begin
                ramready = 1'b1;
                ram_cnt  = 0;
                if (ramWEN) ram_mem[ramaddr] = ramstore;
                else ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
            end
        end else begin
            ram_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_iwait"}, 32'(iwait), 32'd1);
        chk({tag, "_dwait"}, 32'(dwait), 32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_store_done"}, 32'(store_done), 32'd0);
        chk({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        chk({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        chk({tag, "_iload"}, iload, 32'd0);
        chk({tag, "_dload"}, dload, 32'd0);
        chk({tag, "_ramaddr"}, ramaddr, 32'd0);
        chk({tag, "_ramstore"}, ramstore, 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        logic [10:0] seq;
        int          g;
        logic        prev_en;
        logic        found;
        logic        en;
        int          w;
        int          streak_m;
        logic        i_pend, d_pend;
        logic [33:0] e;
        logic [1:0]  op;

        ram_mem[32'h100] = 32'hDEAD_BEEF;

        // Reset and idle
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_en", {30'd0, ramREN, ramWEN}, 32'd0);
        end

        // dcache read, RAM latency 2
        ram_lat = 2;
        dREN = 1'b1; daddr = 32'h100;
        step();
        chk("rd_ramREN_1", 32'(ramREN), 32'd1);
        chk("rd_ramaddr", ramaddr, 32'h100);
        chk("rd_dwait_busy", 32'(dwait), 32'd1);
        step();
        chk("rd_ramREN_2", 32'(ramREN), 32'd1);
        step();
        chk("rd_ramREN_off", 32'(ramREN), 32'd0);
        chk("rd_dwait", 32'(dwait), 32'd0);
        chk("rd_load_done", 32'(load_done), 32'd1);
        chk("rd_store_done", 32'(store_done), 32'd0);
        chk("rd_dload", dload, 32'hDEAD_BEEF);
        dREN = 1'b0;
        step();
        chk("rd_idle_dwait", 32'(dwait), 32'd1);
        chk("rd_idle_done", 32'(load_done), 32'd0);
        chk("rd_idle_state", 32'(dbg_state), 32'(IDLE));

        // Simultaneous fetch and write: write first
        ram_lat = 1;
        iREN = 1'b1; iaddr = 32'h40;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234_5678;
        step();
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h200);
        chk("wr_ramstore", ramstore, 32'h1234_5678);
        chk("wr_iwait_gnt", 32'(iwait), 32'd1);
        step();
        chk("wr_store_done", 32'(store_done), 32'd1);
        chk("wr_dwait", 32'(dwait), 32'd0);
        chk("wr_load_done", 32'(load_done), 32'd0);
        chk("wr_iwait_resp", 32'(iwait), 32'd1);
        dWEN = 1'b0;
        step();
        chk("wr_iwait_idle", 32'(iwait), 32'd1);
        chk("wr_idle_en", 32'(ramREN), 32'd0);
        step();
        chk("if_ramREN", 32'(ramREN), 32'd1);
        chk("if_ramaddr", ramaddr, 32'h40);
        chk("if_iwait_gnt", 32'(iwait), 32'd1);
        step();
        chk("if_iwait", 32'(iwait), 32'd0);
        chk("if_iload", iload, init_word(32'h40));
        chk("if_dwait", 32'(dwait), 32'd1);
        iREN = 1'b0;
        step();
        chk("wr_ram_content", ram_mem.exists(32'h200) ? ram_mem[32'h200] : 32'd0, 32'h1234_5678);

        // Starvation: both held continuously
        iREN = 1'b1; iaddr = 32'h80;
        dREN = 1'b1; daddr = 32'h500;
        g = 0; prev_en = 1'b0; seq = '0;
        for (int c = 0; c < 300 && g < 11; c++) begin
            step();
            if (ramREN && !prev_en) begin
                seq[g] = (ramaddr == 32'h80);
                g++;
            end
            prev_en = ramREN;
        end
        chk("starve_grants", g, 11);
        for (int k = 0; k < 11; k++)
            chk($sformatf("starve_grant_%0d", k), 32'(seq[k]), (k == 4 || k == 9) ? 32'd1 : 32'd0);
        iREN = 1'b0; dREN = 1'b0;
        repeat (8) step();
        chk("starve_settle", 32'(dbg_state), 32'(IDLE));

        // Stale response
        ram_lat = 3;
        dREN = 1'b1; daddr = 32'h300;
        step();
        chk("stale_ramaddr", ramaddr, 32'h300);
        chk("stale_ramREN", 32'(ramREN), 32'd1);
        daddr = 32'h304;
        repeat (3) step();
        chk("stale_resp_dwait", 32'(dwait), 32'd1);
        chk("stale_resp_done", 32'(load_done), 32'd0);
        chk("stale_resp_en", 32'(ramREN), 32'd0);
        step();
        chk("stale_idle_en", 32'(ramREN), 32'd0);
        step();
        chk("stale_regnt_en", 32'(ramREN), 32'd1);
        chk("stale_regnt_addr", ramaddr, 32'h304);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = !dwait;
        end
        chk("stale_resp_seen", 32'(found), 32'd1);
        chk("stale_dload", dload, init_word(32'h304));
        chk("stale_load_done", 32'(load_done), 32'd1);
        dREN = 1'b0;
        step();

        // Reset during a write grant
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'hCAFE_F00D;
        step();
        chk("rst_pre_ramWEN", 32'(ramWEN), 32'd1);
        #3 RST = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        dWEN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_after_store_done", 32'(store_done), 32'd0);
            chk("rst_after_ramWEN", 32'(ramWEN), 32'd0);
        end
        chk("rst_no_write", 32'(ram_mem.exists(32'h600)), 32'd0);

        // Randomized traffic against the transaction-level model
        ram_lat = 0;
        streak_m = 0; i_pend = 1'b0; d_pend = 1'b0; prev_en = 1'b0;
        for (int cyc = 0; cyc < 2700; cyc++) begin
            step();
            en = ramREN || ramWEN;
            if (en && !prev_en) begin
                if (iREN && streak_m == DMAX) w = 0;
                else if (dWEN) w = 2;
                else if (dREN) w = 1;
                else if (iREN) w = 0;
                else w = 3;
                chk("rnd_grant_expected", 32'(w != 3), 32'd1);
                if (w == 0) begin
                    chk("rnd_i_en", {30'd0, ramREN, ramWEN}, 32'd2);
                    chk("rnd_i_addr", ramaddr, iaddr);
                    exp_q.push_back({2'd0, ref_rd(iaddr)});
                    streak_m = 0;
                end else if (w != 3) begin
                    if (iREN && streak_m < DMAX) streak_m++;
                    chk("rnd_d_addr", ramaddr, daddr);
                    if (w == 2) begin
                        chk("rnd_w_en", {30'd0, ramREN, ramWEN}, 32'd1);
                        chk("rnd_w_data", ramstore, dstore);
                        ref_mem[daddr] = dstore;
                        exp_q.push_back({2'd2, dstore});
                    end else begin
                        chk("rnd_r_en", {30'd0, ramREN, ramWEN}, 32'd2);
                        exp_q.push_back({2'd1, ref_rd(daddr)});
                    end
                end
            end
            prev_en = en;
            chk("rnd_one_wait", 32'(iwait | dwait), 32'd1);
            if (!iwait) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                chk("rnd_i_side", 32'(e[33:32]), 32'd0);
                chk("rnd_iload", iload, e[31:0]);
                iREN = 1'b0; i_pend = 1'b0;
            end
            if (!dwait) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                chk("rnd_d_side_ok", 32'(e[33:32] == 2'd1 || e[33:32] == 2'd2), 32'd1);
                chk("rnd_load_done", 32'(load_done), 32'(e[33:32] == 2'd1));
                chk("rnd_store_done", 32'(store_done), 32'(e[33:32] == 2'd2));
                if (e[33:32] == 2'd1) chk("rnd_dload", dload, e[31:0]);
                dREN = 1'b0; dWEN = 1'b0; d_pend = 1'b0;
            end else begin
                chk("rnd_no_done", {30'd0, load_done, store_done}, 32'd0);
            end
            if (cyc < 2500) begin
                if (!i_pend && $urandom_range(0, 3) == 0) begin
                    iREN = 1'b1; iaddr = 32'h1000 + 32'($urandom_range(0, 7)) * 4; i_pend = 1'b1;
                end
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    op = 2'($urandom_range(1, 3));
                    dREN = op[0]; dWEN = op[1];
                    daddr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                    dstore = $urandom; d_pend = 1'b1;
                end
            end
        end
        chk("rnd_drained", exp_q.size(), 32'd0);
        chk("rnd_no_pending", {30'd0, i_pend, d_pend}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
